// File: rtl/execute_stage.sv
// Execute stage: single-cycle RV32I ALU/branch compare plus an iterative
// RV32M multiply/divide unit that stalls upstream while it runs.

package rvga_pkg;
  localparam logic [6:0] opc_op        = 7'b0110011;
  localparam logic [6:0] funct7_muldiv = 7'b0000001;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        imm_v;
    logic        addpc_v;
    logic        jmp_v;
    logic        br_v;
    logic        wb_v;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } rvga_decode_cword;

  typedef struct packed {
    rvga_decode_cword dec;
    logic [31:0]      alu_result;
    logic             bru_result;
  } rvga_execute_cword;
endpackage

// state     | meaning
// st_idle   | no M op in flight; base ops flow through in one cycle
// st_busy   | one mul/div step per cycle, upstream stalled, bubbles out
// st_done   | result ready; retires into the output register when not stalled
module execute_stage
  import rvga_pkg::*;
#(
  parameter int xlen_p = 32,
  parameter int iter_p = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_v_i,
  input  logic              flush_v_i,
  input  rvga_decode_cword  cword_i,
  output rvga_execute_cword cword_o,
  output logic              stall_v_o
);

  localparam int cnt_w = $clog2(iter_p);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(iter_p - 1);

  typedef enum logic [1:0] {st_idle, st_busy, st_done} state_e;

  state_e            state_q;
  rvga_decode_cword  lat_q;
  logic [xlen_p-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic [cnt_w-1:0]  cnt_q;
  logic              q_neg_q, r_neg_q;
  rvga_execute_cword out_q;

  logic              m_op;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [xlen_p-1:0] a_mag, b_mag;
  logic [31:0]       alu_opb, alu_res;
  logic [4:0]        shamt;
  logic              bru_res;
  logic [xlen_p:0]   mul_sum, div_rem_sh, div_diff;
  logic [xlen_p-1:0] hi_d, lo_d;
  logic [2*xlen_p-1:0] prod, prod_fix;
  logic [xlen_p-1:0] quot, remv, m_result;
  logic              div0;
  rvga_execute_cword base_word, out_d;

  assign m_op = cword_i.v & (cword_i.opcode == opc_op) & (cword_i.funct7 == funct7_muldiv);

  // funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
  assign a_signed = (cword_i.funct3 == 3'b001) | (cword_i.funct3 == 3'b010) |
                    (cword_i.funct3 == 3'b100) | (cword_i.funct3 == 3'b110);
  assign b_signed = (cword_i.funct3 == 3'b001) | (cword_i.funct3 == 3'b100) |
                    (cword_i.funct3 == 3'b110);
  assign a_neg    = a_signed & cword_i.rs1_data[31];
  assign b_neg    = b_signed & cword_i.rs2_data[31];
  assign a_mag    = a_neg ? -cword_i.rs1_data : cword_i.rs1_data;
  assign b_mag    = b_neg ? -cword_i.rs2_data : cword_i.rs2_data;

  // Base ALU result for the word currently presented.
  always_comb begin
    alu_opb = cword_i.imm_v ? cword_i.imm : cword_i.rs2_data;
    shamt   = alu_opb[4:0];
    alu_res = '0;
    if (cword_i.jmp_v) begin
      alu_res = cword_i.pc + 32'd4;
    end else if (cword_i.addpc_v) begin
      alu_res = cword_i.pc + cword_i.imm;
    end else begin
      case (cword_i.funct3)
        3'b000: alu_res = (!cword_i.imm_v && cword_i.funct7[5]) ? cword_i.rs1_data - alu_opb
                                                                : cword_i.rs1_data + alu_opb;
        3'b001: alu_res = cword_i.rs1_data << shamt;
        3'b010: alu_res = {31'b0, $signed(cword_i.rs1_data) < $signed(alu_opb)};
        3'b011: alu_res = {31'b0, cword_i.rs1_data < alu_opb};
        3'b100: alu_res = cword_i.rs1_data ^ alu_opb;
        3'b101: alu_res = cword_i.funct7[5] ? 32'($signed(cword_i.rs1_data) >>> shamt)
                                            : cword_i.rs1_data >> shamt;
        3'b110: alu_res = cword_i.rs1_data | alu_opb;
        default: alu_res = cword_i.rs1_data & alu_opb;
      endcase
    end
  end

  // Branch compare of rs1 against rs2; non-branch funct3 codes compare false.
  always_comb begin
    case (cword_i.funct3)
      3'b000:  bru_res = cword_i.rs1_data == cword_i.rs2_data;
      3'b001:  bru_res = cword_i.rs1_data != cword_i.rs2_data;
      3'b100:  bru_res = $signed(cword_i.rs1_data) <  $signed(cword_i.rs2_data);
      3'b101:  bru_res = $signed(cword_i.rs1_data) >= $signed(cword_i.rs2_data);
      3'b110:  bru_res = cword_i.rs1_data <  cword_i.rs2_data;
      3'b111:  bru_res = cword_i.rs1_data >= cword_i.rs2_data;
      default: bru_res = 1'b0;
    endcase
  end

  // One iteration: shift-add multiply (hi:lo holds partial product : multiplier)
  // or restoring divide (hi:lo holds remainder : dividend/quotient).
  always_comb begin
    mul_sum    = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : '0)};
    div_rem_sh = {acc_hi_q, acc_lo_q[xlen_p-1]};
    div_diff   = div_rem_sh - {1'b0, opb_q};
    if (lat_q.funct3[2]) begin
      if (!div_diff[xlen_p]) begin
        hi_d = div_diff[xlen_p-1:0];
        lo_d = {acc_lo_q[xlen_p-2:0], 1'b1};
      end else begin
        hi_d = div_rem_sh[xlen_p-1:0];
        lo_d = {acc_lo_q[xlen_p-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[xlen_p:1];
      lo_d = {mul_sum[0], acc_lo_q[xlen_p-1:1]};
    end
  end

  // Sign correction and word select once iteration has finished.
  always_comb begin
    div0     = (lat_q.rs2_data == '0);
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = q_neg_q ? -prod : prod;
    quot     = div0 ? '1 : (q_neg_q ? -acc_lo_q : acc_lo_q);
    remv     = div0 ? lat_q.rs1_data : (r_neg_q ? -acc_hi_q : acc_hi_q);
    case (lat_q.funct3)
      3'b000:                 m_result = prod_fix[xlen_p-1:0];
      3'b001, 3'b010, 3'b011: m_result = prod_fix[2*xlen_p-1:xlen_p];
      3'b100, 3'b101:         m_result = quot;
      default:                m_result = remv;
    endcase
  end

  // Next output word: flush and in-flight M ops produce bubbles.
  always_comb begin
    base_word = '0;
    if (cword_i.v) begin
      base_word.dec        = cword_i;
      base_word.alu_result = alu_res;
      base_word.bru_result = bru_res;
    end
    out_d = base_word;
    if (flush_v_i) begin
      out_d = '0;
    end else if (state_q == st_busy) begin
      out_d = '0;
    end else if (state_q == st_done) begin
      out_d.dec        = lat_q;
      out_d.alu_result = m_result;
      out_d.bru_result = 1'b0;
    end else if (m_op) begin
      out_d = '0;
    end
  end

  // M unit sequencer; iteration keeps running under stall_v_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= st_idle;
      lat_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else if (flush_v_i) begin
      state_q <= st_idle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        st_idle: begin
          if (m_op && !stall_v_i) begin
            lat_q    <= cword_i;
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            state_q  <= st_busy;
            if (cword_i.funct3[2]) begin
              acc_lo_q <= a_mag;
              opb_q    <= b_mag;
            end else begin
              acc_lo_q <= b_mag;
              opb_q    <= a_mag;
            end
          end
        end
        st_busy: begin
          acc_hi_q <= hi_d;
          acc_lo_q <= lo_d;
          cnt_q    <= cnt_q + cnt_w'(1);
          if (cnt_q == cnt_last) state_q <= st_done;
        end
        st_done: begin
          if (!stall_v_i) state_q <= st_idle;
        end
        default: state_q <= st_idle;
      endcase
    end
  end

  // Output register; flush overrides a downstream hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_q <= '0;
    end else if (!stall_v_i || flush_v_i) begin
      out_q <= out_d;
    end
  end

  assign cword_o = out_q;

  // Gated by reset so the hold drops immediately while reset is asserted.
  assign stall_v_o = rst_i & ((state_q == st_busy) |
                              ((state_q == st_idle) & m_op & !flush_v_i));

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline stage directly upstream of the memory stage.
- Consumes the decode control word and produces the registered execute control word (rvga_execute_cword) that the memory stage takes as its input.
- Base RV32I ALU and branch-compare ops complete in one cycle.
- RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) run in an internal iterative unit. The stage stalls upstream and inserts bubbles downstream while that unit runs.

Parameters:
- xlen_p, 32, datapath width. Only 32 is supported.
- iter_p, 32, multiply/divide iterations, one bit per cycle. Must equal xlen_p.

Ports:
- clk_i  in  1  clock, all state rising-edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_v_i  in  1  hazard unit hold. Output register keeps its value.
- flush_v_i  in  1  squash. Output register loads nop; any M op in flight is aborted.
- cword_i  in  $bits(rvga_decode_cword)  decoded instruction: v, pc, opcode, rs1/rs2/rd, funct3, funct7, control flags, imm, rs1_data, rs2_data.
- cword_o  out  $bits(rvga_execute_cword)  registered result word: all decode fields plus alu_result and bru_result.
- stall_v_o  out  1  M unit busy. Hazard unit holds fetch and decode.

Behaviour:
- Reset (rst_i=0, async): FSM=IDLE, output register='0 (nop), iteration counter=0, operand/accumulator registers=0, stall_v_o=0.
- M op detect: cword_i.v & opcode==OP (0110011) & funct7==0000001. Every other valid word is a base op.
- Base op:
  - alu_result computed combinationally: add/sub/sll/slt/sltu/xor/srl/sra/or/and, imm form when imm_v, pc+imm when addpc_v, pc+4 when jmp_v.
  - bru_result = funct3 compare (beq/bne/blt/bge/bltu/bgeu) of rs1_data vs rs2_data.
  - Latency 1: visible on cword_o the cycle after presentation, unless stall_v_i.
- Output register write enable = !stall_v_i | flush_v_i. Input mux priority: flush → nop; FSM not IDLE/DONE → nop; else computed word.
- FSM states:
  - IDLE → BUSY: on M op with !flush_v_i & !stall_v_i. Latch the full cword_i, operand magnitudes, sign flags, op kind; counter=0.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle. After the step with counter==iter_p-1 → DONE. stall_v_i does not pause iteration.
  - DONE: apply sign correction; select low/high product word or quotient/remainder. When !stall_v_i, write the output register with the latched cword plus the result as alu_result, then → IDLE. Otherwise hold in DONE.
  - Any state → IDLE: on flush_v_i. Counter cleared; output register loads nop.
- stall_v_o = (state==BUSY) | (state==IDLE & M op & !flush_v_i). It is 0 in DONE so upstream advances on the same edge the result retires.
- Latency: an M op presented in cycle N is accepted at end of N, iterates 32 cycles, spends 1 cycle in DONE, and is visible on cword_o from cycle N+34.
- Downstream sees bubbles (v=0) for cycles N+1..N+33.
- Arithmetic:
  - 64-bit product.
  - MULH: signed×signed. MULHSU: rs1 signed, rs2 unsigned. Negate the 64-bit magnitude product when signs differ.
  - Division by zero: quotient=0xFFFFFFFF (DIV and DIVU), remainder=dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0.
  - Remainder sign follows the dividend.
  - Zero-divisor and overflow cases still take the full 34-cycle latency.
- Simultaneous stall_v_i & flush_v_i: flush wins.
- rst_i deasserting mid-operation: none of the earlier state survives. The FSM restarts from IDLE.

Test Plan:
- ADD, rs1=5, rs2=0xFFFFFFFD, no stall → next cycle cword_o.v=1, alu_result=0x00000002. BEQ with equal operands → bru_result=1.
- MUL 7×0xFFFFFFFD in cycle 0 → stall_v_o=1 for cycles 0..32, 0 in cycle 33. cword_o.v=0 for cycles 1..33. Cycle 34: v=1, alu_result=0xFFFFFFEB, pc/rd preserved.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of same → 0. DIVU 10/0 → 0xFFFFFFFF; REMU 10/0 → 10. Each takes 34 cycles.
- DIV issued, flush_v_i pulsed on BUSY iteration 10 → stall_v_o=0 the following cycle, cword_o=nop, no result ever emitted. A following ADD completes in 1 cycle.
- REM issued, stall_v_i held 5 cycles on reaching DONE → cword_o unchanged and FSM in DONE throughout. Result appears the cycle after release.
- Reset asserted during BUSY → cword_o='0 and stall_v_o=0 immediately (async).
